// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser followed by a four-state debounce
// FSM with registered level and one-clock rise/fall strobes.
// Optional auto-repeat strobe while held, enabled by DEBOUNCER_AUTO_REPEAT_EN.
module button_debouncer #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int ACTIVE_LOW    = 0,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_db,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_repeat
);

  localparam int MAX_SH  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_SH > REPEAT_CYCLES) ? MAX_SH : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic          IN_INV      = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_RISE_WAIT,
    ST_HIGH,
    ST_FALL_WAIT
  } state_t;

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

`ifdef DEBOUNCER_AUTO_REPEAT_EN
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;  // first (HOLD) repeat already issued
  logic          repeat_q, repeat_d;
  logic [CW-1:0] rep_target;
`endif

  // Saturating increment so a long stable window can never wrap the counter
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // Next-state logic for synchroniser, debounce FSM and strobes
  always_comb begin
    s1_d    = btn_in ^ IN_INV;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_LOW: begin
        if (s2_q) begin
          state_d = ST_RISE_WAIT;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_RISE_WAIT: begin
        if (!s2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HIGH;
          db_d    = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      ST_HIGH: begin
        if (!s2_q) begin
          state_d = ST_FALL_WAIT;
          cnt_d   = CW'(1);
        end
      end
      ST_FALL_WAIT: begin
        if (s2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_LOW;
          db_d    = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef DEBOUNCER_AUTO_REPEAT_EN
  assign rep_target = rep_first_q ? REPEAT_LAST : HOLD_LAST;

  // Auto-repeat timing: only advances while the FSM stays in HIGH
  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = 1'b0;
    repeat_d    = 1'b0;
    if (state_q == ST_HIGH && s2_q) begin
      if (rep_cnt_q == rep_target) begin
        repeat_d    = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
      end else begin
        rep_cnt_d   = (rep_cnt_q == CNT_MAX) ? rep_cnt_q : rep_cnt_q + CW'(1);
        rep_first_d = rep_first_q;
      end
    end
  end
`endif

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`ifdef DEBOUNCER_AUTO_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
      repeat_q    <= 1'b0;
`endif
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`ifdef DEBOUNCER_AUTO_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      repeat_q    <= repeat_d;
`endif
    end
  end

  assign btn_db   = db_q;
  assign btn_rise = rise_q;
  assign btn_fall = fall_q;
`ifdef DEBOUNCER_AUTO_REPEAT_EN
  assign btn_repeat = repeat_q;
`else
  assign btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus pushes expected strobe
// events (kind + edge number), a negedge monitor pops and compares them.
module tb_button_debouncer;

  localparam int K_RISE = 1;
  localparam int K_FALL = 2;
  localparam int K_REP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b0;
  logic btn_db, btn_rise, btn_fall, btn_repeat;

  int edge_n = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int kind;
    int edge_at;
  } ev_t;
  ev_t exp_q[$];

  button_debouncer #(
    .STABLE_CYCLES(4),
    .ACTIVE_LOW(0),
    .HOLD_CYCLES(8),
    .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_db(btn_db),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .btn_repeat(btn_repeat)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string kname(input int k);
    case (k)
      K_RISE:  return "rise";
      K_FALL:  return "fall";
      K_REP:   return "repeat";
      default: return "none";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, edge_n);
    end else begin
      $display("check %s: %0d ok (edge %0d)", name, act, edge_n);
    end
  endtask

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind    = kind;
    e.edge_at = at;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      btn_in = v;
      @(negedge clk);
    end
  endtask

  task automatic got_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: strobe at edge %0d, none expected", kname(kind), edge_n);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.edge_at != edge_n) begin
        errors++;
        $display("FAIL event: got %s at edge %0d expected %s at edge %0d",
                 kname(kind), edge_n, kname(e.kind), e.edge_at);
      end else begin
        $display("event %s at edge %0d ok", kname(kind), edge_n);
      end
    end
  endtask

  // Monitor: every strobe seen must match the head of the scoreboard
  always @(negedge clk) begin
    if (btn_rise || btn_fall) begin
      checks++;
      if (btn_rise && btn_fall) begin
        errors++;
        $display("FAIL rise_fall_overlap: both strobes high at edge %0d", edge_n);
      end
    end
    if (btn_rise)   got_ev(K_RISE);
    if (btn_fall)   got_ev(K_FALL);
    if (btn_repeat) got_ev(K_REP);
  end

  initial begin
    int k;

    // 1: reset held with button pressed
    rst = 1'b0;
    hold(1'b1, 3);
    chk("reset_db", int'(btn_db), 0);
    chk("reset_rise", int'(btn_rise), 0);
    chk("reset_fall", int'(btn_fall), 0);
    chk("reset_repeat", int'(btn_repeat), 0);
    rst = 1'b1;
    k = edge_n;
    expect_ev(K_RISE, k + 6);
    hold(1'b1, 5);
    chk("post_reset_db_before_window", int'(btn_db), 0);
    hold(1'b1, 1);
    chk("post_reset_db_after_window", int'(btn_db), 1);

    // 4a: clean release
    k = edge_n;
    expect_ev(K_FALL, k + 6);
    hold(1'b0, 5);
    chk("release_db_before", int'(btn_db), 1);
    hold(1'b0, 1);
    chk("release_db_after", int'(btn_db), 0);

    // 2: clean press
    k = edge_n;
    expect_ev(K_RISE, k + 6);
    hold(1'b1, 5);
    chk("press_db_e4", int'(btn_db), 0);
    hold(1'b1, 1);
    chk("press_db_e5", int'(btn_db), 1);
    chk("press_rise_e5", int'(btn_rise), 1);
    hold(1'b1, 1);
    chk("press_rise_e6", int'(btn_rise), 0);

    // 4b: 3-clock low glitch while HIGH is rejected
    hold(1'b0, 3);
    hold(1'b1, 4);
    chk("glitch_db", int'(btn_db), 1);
    k = edge_n;
    expect_ev(K_FALL, k + 6);
    hold(1'b0, 6);
    chk("glitch_release_db", int'(btn_db), 0);

    // 3: bounce 1,0,1,0 then hold 1
    hold(1'b1, 1);
    hold(1'b0, 1);
    hold(1'b1, 1);
    hold(1'b0, 1);
    k = edge_n;
    expect_ev(K_RISE, k + 6);
    hold(1'b1, 5);
    chk("bounce_db_before", int'(btn_db), 0);
    hold(1'b1, 1);
    chk("bounce_db_after", int'(btn_db), 1);
    k = edge_n;
    expect_ev(K_FALL, k + 6);
    hold(1'b0, 6);
    chk("bounce_release_db", int'(btn_db), 0);

    // 5: reset in RISE_WAIT with cnt=2
    hold(1'b1, 4);
    rst = 1'b0;
    hold(1'b1, 2);
    chk("midreset_db", int'(btn_db), 0);
    chk("midreset_rise", int'(btn_rise), 0);
    rst = 1'b1;
    hold(1'b0, 10);
    chk("midreset_after_db", int'(btn_db), 0);

    // 6: long hold, repeat strobes (only with the macro)
    k = edge_n;
    expect_ev(K_RISE, k + 6);
`ifdef DEBOUNCER_AUTO_REPEAT_EN
    expect_ev(K_REP, k + 14);
    expect_ev(K_REP, k + 17);
    expect_ev(K_REP, k + 20);
    expect_ev(K_REP, k + 23);
`endif
    hold(1'b1, 22);
    chk("hold_db", int'(btn_db), 1);
    k = edge_n;
    expect_ev(K_FALL, k + 6);
    hold(1'b0, 12);
    chk("hold_release_db", int'(btn_db), 0);

    // Everything expected must have arrived
    hold(1'b0, 4);
    chk("scoreboard_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
